lp805x_sfrport: RTL and testbench

Peripheral-side SFR endpoint of the lp805x read handshake. It decodes its SFR address, buffers up to two peripheral samples in a small FIFO, and announces each sample to the SFR sync controller with a one-cycle `sfr_prrdy` pulse. It holds the sample on `sfr_dat` until the controller's `sfr_pput` completion pulse, then pops it. It also forwards CPU SFR writes to the peripheral as a registered strobe.

---
 rtl/lp805x_sfr_pkg.sv | 14 +
 rtl/lp805x_sfrport_fifo.sv | 46 ++++
 rtl/lp805x_sfrport.sv | 107 ++++++++++
 tb/tb_lp805x_sfrport.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/lp805x_sfr_pkg.sv
// Shared types and sizing for the lp805x SFR read endpoint.
package lp805x_sfr_pkg;

  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = 2;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    ANNOUNCE = 2'd1,
    WAIT     = 2'd2,
    POP      = 2'd3
  } sfr_state_e;

endpackage

// File: rtl/lp805x_sfrport_fifo.sv
// Two-entry sample FIFO. Pointers are single bits, so they wrap modulo 2.
module lp805x_sfrport_fifo
  import lp805x_sfr_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [DW-1:0]    i_din,
  output logic [DW-1:0]    o_head,
  output logic [CNT_W-1:0] o_count
);

  logic [FIFO_DEPTH-1:0][DW-1:0] r_mem;
  logic                          r_wptr;
  logic                          r_rptr;
  logic [CNT_W-1:0]              r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem  <= '0;
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= ~r_wptr;
      end
      if (i_pop)
        r_rptr <= ~r_rptr;
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_cnt;

endmodule

// File: rtl/lp805x_sfrport.sv
// lp805x SFR read endpoint: FIFO-backed prrdy/pput handshake plus a registered
// write path. Define LP805X_SFRPORT_OVF_EN to add the sticky sfr_ovf flag.
module lp805x_sfrport
  import lp805x_sfr_pkg::*;
#(
  parameter int         DW   = 8,
  parameter logic [7:0] ADDR = 8'h80
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    sfr_addr,
  output logic          sfr_this,
  input  logic [DW-1:0] per_dat,
  input  logic          per_vld,
  output logic          sfr_prrdy,
  input  logic          sfr_pget,
  output logic          sfr_pwrdy,
  input  logic          sfr_pput,
  output logic [DW-1:0] sfr_dat,
  input  logic          sfr_wr,
  input  logic [DW-1:0] sfr_wdat,
  output logic          per_we,
  output logic [DW-1:0] per_wdat
`ifdef LP805X_SFRPORT_OVF_EN
  ,output logic         sfr_ovf
`endif
);

  sfr_state_e       r_state, w_nxt;
  logic [DW-1:0]    w_head;
  logic [CNT_W-1:0] w_cnt;
  logic             w_full, w_pop, w_push, w_wr_hit;
  logic [DW-1:0]    r_dat;
  logic             r_per_we;
  logic [DW-1:0]    r_per_wdat;
  logic             w_unused_pget;

  // The read token is informational only; the handshake runs on prrdy/pput.
  assign w_unused_pget = sfr_pget;

  assign sfr_this = (sfr_addr == ADDR);
  assign w_wr_hit = sfr_wr & sfr_this;
  assign w_full   = (w_cnt == CNT_W'(FIFO_DEPTH));
  assign w_pop    = sfr_pput & (r_state == WAIT);
  assign w_push   = per_vld & (~w_full | w_pop);

  lp805x_sfrport_fifo #(.DW(DW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (per_dat),
    .o_head  (w_head),
    .o_count (w_cnt)
  );

  // In POP the count register already reflects the committed pop.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      EMPTY:    if (w_cnt != '0) w_nxt = ANNOUNCE;
      ANNOUNCE: w_nxt = WAIT;
      WAIT:     if (sfr_pput) w_nxt = POP;
      POP:      w_nxt = (w_cnt != '0) ? ANNOUNCE : EMPTY;
      default:  w_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= EMPTY;
      r_dat      <= '0;
      r_per_we   <= 1'b0;
      r_per_wdat <= '0;
    end else begin
      r_state  <= w_nxt;
      if (w_nxt == ANNOUNCE && r_state != ANNOUNCE)
        r_dat <= w_head;
      r_per_we <= w_wr_hit;
      if (w_wr_hit)
        r_per_wdat <= sfr_wdat;
    end
  end

  assign sfr_prrdy = (r_state == ANNOUNCE);
  assign sfr_pwrdy = (r_state == WAIT) & ~r_per_we;
  assign sfr_dat   = r_dat;
  assign per_we    = r_per_we;
  assign per_wdat  = r_per_wdat;

`ifdef LP805X_SFRPORT_OVF_EN
  logic w_drop;
  logic r_ovf;

  assign w_drop = per_vld & w_full & ~w_pop;

  // A drop in the same cycle as a clearing write keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_ovf <= 1'b0;
    else if (w_drop)   r_ovf <= 1'b1;
    else if (w_wr_hit) r_ovf <= 1'b0;
  end

  assign sfr_ovf = r_ovf;
`endif

endmodule

// File: tb/tb_lp805x_sfrport.sv
// Directed self-checking bench for lp805x_sfrport (default DW=8, ADDR=8'h80).
module tb_lp805x_sfrport;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sfr_addr = 8'h00;
  logic       sfr_this;
  logic [7:0] per_dat = 8'h00;
  logic       per_vld = 1'b0;
  logic       sfr_prrdy;
  logic       sfr_pget = 1'b0;
  logic       sfr_pwrdy;
  logic       sfr_pput = 1'b0;
  logic [7:0] sfr_dat;
  logic       sfr_wr = 1'b0;
  logic [7:0] sfr_wdat = 8'h00;
  logic       per_we;
  logic [7:0] per_wdat;
`ifdef LP805X_SFRPORT_OVF_EN
  logic       sfr_ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lp805x_sfrport dut (
    .clk       (clk),
    .rst       (rst),
    .sfr_addr  (sfr_addr),
    .sfr_this  (sfr_this),
    .per_dat   (per_dat),
    .per_vld   (per_vld),
    .sfr_prrdy (sfr_prrdy),
    .sfr_pget  (sfr_pget),
    .sfr_pwrdy (sfr_pwrdy),
    .sfr_pput  (sfr_pput),
    .sfr_dat   (sfr_dat),
    .sfr_wr    (sfr_wr),
    .sfr_wdat  (sfr_wdat),
    .per_we    (per_we),
    .per_wdat  (per_wdat)
`ifdef LP805X_SFRPORT_OVF_EN
    ,.sfr_ovf  (sfr_ovf)
`endif
  );

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    step();
    step();
    checks++; if (sfr_prrdy !== 1'b0) begin errors++; $display("FAIL rst_prrdy got %0b exp 0", sfr_prrdy); end
    checks++; if (sfr_pwrdy !== 1'b0) begin errors++; $display("FAIL rst_pwrdy got %0b exp 0", sfr_pwrdy); end
    checks++; if (sfr_dat !== 8'h00) begin errors++; $display("FAIL rst_dat got %h exp 00", sfr_dat); end
    checks++; if (per_we !== 1'b0 || per_wdat !== 8'h00) begin errors++; $display("FAIL rst_wr got %0b/%h exp 0/00", per_we, per_wdat); end
`ifdef LP805X_SFRPORT_OVF_EN
    checks++; if (sfr_ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %0b exp 0", sfr_ovf); end
`endif
    rst = 1'b1;
    step();
  endtask

  task automatic test_single();
    per_vld = 1'b1; per_dat = 8'hA5;
    step();                                  // edge N
    per_vld = 1'b0;
    checks++; if (sfr_prrdy !== 1'b0) begin errors++; $display("FAIL single_prrdy_N got %0b exp 0", sfr_prrdy); end
    step();                                  // N+1: ANNOUNCE
    checks++; if (sfr_prrdy !== 1'b1) begin errors++; $display("FAIL single_prrdy_N1 got %0b exp 1", sfr_prrdy); end
    checks++; if (sfr_dat !== 8'hA5) begin errors++; $display("FAIL single_dat got %h exp a5", sfr_dat); end
    checks++; if (sfr_pwrdy !== 1'b0) begin errors++; $display("FAIL single_pwrdy_N1 got %0b exp 0", sfr_pwrdy); end
    step();                                  // N+2: WAIT
    checks++; if (sfr_prrdy !== 1'b0) begin errors++; $display("FAIL single_prrdy_N2 got %0b exp 0", sfr_prrdy); end
    checks++; if (sfr_pwrdy !== 1'b1) begin errors++; $display("FAIL single_pwrdy_N2 got %0b exp 1", sfr_pwrdy); end
    step();
    checks++; if (sfr_pwrdy !== 1'b1 || sfr_prrdy !== 1'b0) begin errors++; $display("FAIL single_hold got %0b/%0b exp 1/0", sfr_pwrdy, sfr_prrdy); end
    sfr_pput = 1'b1;
    step();                                  // POP
    sfr_pput = 1'b0;
    checks++; if (sfr_pwrdy !== 1'b0 || sfr_prrdy !== 1'b0) begin errors++; $display("FAIL single_pop got %0b/%0b exp 0/0", sfr_pwrdy, sfr_prrdy); end
    step();                                  // EMPTY
    step();
    checks++; if (sfr_pwrdy !== 1'b0 || sfr_prrdy !== 1'b0) begin errors++; $display("FAIL single_empty got %0b/%0b exp 0/0", sfr_pwrdy, sfr_prrdy); end
    checks++; if (sfr_dat !== 8'hA5) begin errors++; $display("FAIL single_dat_held got %h exp a5", sfr_dat); end
  endtask

  task automatic test_overflow();
    per_vld = 1'b1; per_dat = 8'h11;
    step();
    per_dat = 8'h22;
    step();                                  // ANNOUNCE 11, count 2
    checks++; if (sfr_prrdy !== 1'b1 || sfr_dat !== 8'h11) begin errors++; $display("FAIL ovf_ann1 got %0b/%h exp 1/11", sfr_prrdy, sfr_dat); end
    per_dat = 8'h33;
    step();                                  // 33 dropped, WAIT
    per_vld = 1'b0;
    checks++; if (sfr_pwrdy !== 1'b1 || sfr_dat !== 8'h11) begin errors++; $display("FAIL ovf_wait1 got %0b/%h exp 1/11", sfr_pwrdy, sfr_dat); end
`ifdef LP805X_SFRPORT_OVF_EN
    checks++; if (sfr_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b exp 1", sfr_ovf); end
`endif
    sfr_pput = 1'b1;
    step();
    sfr_pput = 1'b0;
    step();                                  // ANNOUNCE 22
    checks++; if (sfr_prrdy !== 1'b1 || sfr_dat !== 8'h22) begin errors++; $display("FAIL ovf_ann2 got %0b/%h exp 1/22", sfr_prrdy, sfr_dat); end
    step();
    checks++; if (sfr_pwrdy !== 1'b1) begin errors++; $display("FAIL ovf_wait2 got %0b exp 1", sfr_pwrdy); end
    sfr_pput = 1'b1;
    step();
    sfr_pput = 1'b0;
    step();
    checks++; if (sfr_prrdy !== 1'b0 || sfr_pwrdy !== 1'b0) begin errors++; $display("FAIL ovf_drained got %0b/%0b exp 0/0", sfr_prrdy, sfr_pwrdy); end
    step();
    checks++; if (sfr_prrdy !== 1'b0 || sfr_dat !== 8'h22) begin errors++; $display("FAIL ovf_dropped got %0b/%h exp 0/22", sfr_prrdy, sfr_dat); end
  endtask

  task automatic test_push_pop_full();
    per_vld = 1'b1; per_dat = 8'h44;
    step();
    per_dat = 8'h55;
    step();                                  // ANNOUNCE 44
    per_vld = 1'b0;
    step();                                  // WAIT, count 2
    checks++; if (sfr_pwrdy !== 1'b1 || sfr_dat !== 8'h44) begin errors++; $display("FAIL pp_wait got %0b/%h exp 1/44", sfr_pwrdy, sfr_dat); end
    sfr_pput = 1'b1; per_vld = 1'b1; per_dat = 8'h66;
    step();                                  // pop 44, push 66
    sfr_pput = 1'b0; per_vld = 1'b0;
    step();
    checks++; if (sfr_prrdy !== 1'b1 || sfr_dat !== 8'h55) begin errors++; $display("FAIL pp_ann55 got %0b/%h exp 1/55", sfr_prrdy, sfr_dat); end
    step();
    sfr_pput = 1'b1;
    step();
    sfr_pput = 1'b0;
    step();
    checks++; if (sfr_prrdy !== 1'b1 || sfr_dat !== 8'h66) begin errors++; $display("FAIL pp_ann66 got %0b/%h exp 1/66", sfr_prrdy, sfr_dat); end
    step();                                  // WAIT with 66, left for the write test
  endtask

  task automatic test_write();
    sfr_addr = 8'h80; sfr_wr = 1'b1; sfr_wdat = 8'h3C;
    #1;
    checks++; if (sfr_this !== 1'b1) begin errors++; $display("FAIL wr_this got %0b exp 1", sfr_this); end
    step();                                  // edge K
    sfr_wr = 1'b0;
    checks++; if (per_we !== 1'b1 || per_wdat !== 8'h3C) begin errors++; $display("FAIL wr_strobe got %0b/%h exp 1/3c", per_we, per_wdat); end
    checks++; if (sfr_pwrdy !== 1'b0 || sfr_dat !== 8'h66) begin errors++; $display("FAIL wr_pwrdy got %0b/%h exp 0/66", sfr_pwrdy, sfr_dat); end
`ifdef LP805X_SFRPORT_OVF_EN
    checks++; if (sfr_ovf !== 1'b0) begin errors++; $display("FAIL wr_ovf_clr got %0b exp 0", sfr_ovf); end
`endif
    step();
    checks++; if (per_we !== 1'b0 || per_wdat !== 8'h3C || sfr_pwrdy !== 1'b1) begin errors++; $display("FAIL wr_after got %0b/%h/%0b exp 0/3c/1", per_we, per_wdat, sfr_pwrdy); end
    sfr_pput = 1'b1;
    step();
    sfr_pput = 1'b0;
    step();
    checks++; if (sfr_prrdy !== 1'b0) begin errors++; $display("FAIL wr_fifo got %0b exp 0", sfr_prrdy); end
  endtask

  task automatic test_wrong_addr();
    sfr_addr = 8'h81; sfr_wr = 1'b1; sfr_wdat = 8'h5A;
    #1;
    checks++; if (sfr_this !== 1'b0) begin errors++; $display("FAIL na_this got %0b exp 0", sfr_this); end
    step();
    sfr_wr = 1'b0;
    checks++; if (per_we !== 1'b0 || per_wdat !== 8'h3C) begin errors++; $display("FAIL na_we got %0b/%h exp 0/3c", per_we, per_wdat); end
  endtask

  task automatic test_reset_mid();
    per_vld = 1'b1; per_dat = 8'h12;
    step();
    per_dat = 8'h34;
    step();
    per_vld = 1'b0;
    step();                                  // WAIT, two entries
    checks++; if (sfr_pwrdy !== 1'b1 || sfr_dat !== 8'h12) begin errors++; $display("FAIL rm_wait got %0b/%h exp 1/12", sfr_pwrdy, sfr_dat); end
    #2 rst = 1'b0;
    #1;
    checks++; if (sfr_prrdy !== 1'b0 || sfr_pwrdy !== 1'b0 || sfr_dat !== 8'h00) begin errors++; $display("FAIL rm_outs got %0b/%0b/%h exp 0/0/00", sfr_prrdy, sfr_pwrdy, sfr_dat); end
    checks++; if (per_we !== 1'b0 || per_wdat !== 8'h00) begin errors++; $display("FAIL rm_wr got %0b/%h exp 0/00", per_we, per_wdat); end
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (sfr_prrdy !== 1'b0 || sfr_pwrdy !== 1'b0) begin errors++; $display("FAIL rm_idle%0d got %0b/%0b exp 0/0", i, sfr_prrdy, sfr_pwrdy); end
    end
    per_vld = 1'b1; per_dat = 8'h9A;
    step();
    per_vld = 1'b0;
    step();
    checks++; if (sfr_prrdy !== 1'b1 || sfr_dat !== 8'h9A) begin errors++; $display("FAIL rm_new got %0b/%h exp 1/9a", sfr_prrdy, sfr_dat); end
    step();
    sfr_pput = 1'b1;
    step();
    sfr_pput = 1'b0;
    step();
    checks++; if (sfr_prrdy !== 1'b0 || sfr_pwrdy !== 1'b0) begin errors++; $display("FAIL rm_drain got %0b/%0b exp 0/0", sfr_prrdy, sfr_pwrdy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_push_pop_full();
    test_write();
    test_wrong_addr();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
